// File: rtl/hc165_key_reader.sv
// Continuous scanner for a 74HC165 chain: loads, shifts in NUM_BITS MSB-first,
// and debounces whole frames into a stable key word.
module hc165_key_reader #(
  parameter int CLK_DIV         = 25,
  parameter int NUM_BITS        = 32,
  parameter int GAP_PHASES      = 16,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                scan_en,
  output logic                hc165_clk,
  output logic                hc165_ld_n,
  input  logic                hc165_dat,
  output logic [NUM_BITS-1:0] frame_data,
  output logic                frame_valid,
  output logic [NUM_BITS-1:0] key_state,
  output logic                key_changed,
  output logic                busy
);

  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int BIT_W   = $clog2(NUM_BITS);
  localparam int GAP_W   = (GAP_PHASES > 1) ? $clog2(GAP_PHASES) : 1;
  localparam int ST_W    = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int GAP_L_I = (GAP_PHASES > 0) ? GAP_PHASES - 1 : 0;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_L_I);
  localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(DEBOUNCE_FRAMES);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOW, S_HIGH, S_DONE, S_GAP} state_t;

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic [BIT_W-1:0]    r_bit;
  logic [GAP_W-1:0]    r_gap;
  logic                r_clk;
  logic                r_ld_n;
  logic                r_busy;
  logic                r_fv;
  logic                r_kc;
  logic [NUM_BITS-1:0] r_frame;
  logic [NUM_BITS-1:0] r_key;
  logic [NUM_BITS-1:0] r_prev;
  logic [ST_W-1:0]     r_stable;
  logic [NUM_BITS-1:0] r_shift;
  logic                r_dat_s1;
  logic                r_dat_s2;

  logic                w_phase_end;
  logic [ST_W-1:0]     w_stable_nxt;

  assign w_phase_end = (r_div == DIV_LAST);

  // Saturating run-length of identical consecutive frames.
  always_comb begin
    w_stable_nxt = ST_W'(1);
    if (r_shift == r_prev)
      w_stable_nxt = (r_stable >= ST_MAX) ? ST_MAX : r_stable + ST_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    r_dat_s1 <= hc165_dat;
    r_dat_s2 <= r_dat_s1;
  end

  // Bits arrive MSB first, so shifting left leaves bit 0 last.
  always_ff @(posedge sys_clk) begin
    if (r_state == S_LOW && w_phase_end)
      r_shift <= {r_shift[NUM_BITS-2:0], r_dat_s2};
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bit    <= '0;
      r_gap    <= '0;
      r_clk    <= 1'b0;
      r_ld_n   <= 1'b1;
      r_busy   <= 1'b0;
      r_fv     <= 1'b0;
      r_kc     <= 1'b0;
      r_frame  <= '0;
      r_key    <= '0;
      r_prev   <= '0;
      r_stable <= '0;
    end else begin
      r_fv <= 1'b0;
      r_kc <= 1'b0;
      if (r_state inside {S_IDLE, S_DONE} || w_phase_end)
        r_div <= '0;
      else
        r_div <= r_div + DIV_W'(1);

      case (r_state)
        S_IDLE: begin
          if (scan_en) begin
            r_state <= S_LOAD;
            r_ld_n  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_phase_end) begin
            r_state <= S_LOW;
            r_ld_n  <= 1'b1;
            r_bit   <= '0;
          end
        end
        S_LOW: begin
          if (w_phase_end) begin
            if (r_bit == BIT_LAST) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_HIGH;
              r_clk   <= 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (w_phase_end) begin
            r_state <= S_LOW;
            r_clk   <= 1'b0;
            r_bit   <= r_bit + BIT_W'(1);
          end
        end
        S_DONE: begin
          r_frame  <= r_shift;
          r_fv     <= 1'b1;
          r_prev   <= r_shift;
          r_stable <= w_stable_nxt;
          if (w_stable_nxt >= ST_MAX && r_shift != r_key) begin
            r_key <= r_shift;
            r_kc  <= 1'b1;
          end
          r_gap <= '0;
          if (GAP_PHASES != 0) begin
            r_state <= S_GAP;
          end else if (scan_en) begin
            r_state <= S_LOAD;
            r_ld_n  <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_GAP: begin
          if (w_phase_end) begin
            if (r_gap == GAP_LAST) begin
              if (scan_en) begin
                r_state <= S_LOAD;
                r_ld_n  <= 1'b0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_gap <= r_gap + GAP_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_clk   <= 1'b0;
          r_ld_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hc165_clk   = r_clk;
  assign hc165_ld_n  = r_ld_n;
  assign frame_data  = r_frame;
  assign frame_valid = r_fv;
  assign key_state   = r_key;
  assign key_changed = r_kc;
  assign busy        = r_busy;

endmodule

// File: tb/tb_hc165_key_reader.sv
// Directed bench: two reader instances, each fed by a behavioural 74HC165 chain.
module tb_hc165_key_reader;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic sys_rst_n = 1'b0;
  logic scan_en_a = 1'b0;
  logic scan_en_b = 1'b0;

  logic        clk_a, ldn_a, dat_a, fv_a, kc_a, busy_a;
  logic [31:0] fd_a, ks_a;
  logic        clk_b, ldn_b, dat_b, fv_b, kc_b, busy_b;
  logic [7:0]  fd_b, ks_b;

  hc165_key_reader dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .scan_en(scan_en_a),
    .hc165_clk(clk_a), .hc165_ld_n(ldn_a), .hc165_dat(dat_a),
    .frame_data(fd_a), .frame_valid(fv_a), .key_state(ks_a),
    .key_changed(kc_a), .busy(busy_a)
  );

  hc165_key_reader #(.CLK_DIV(4), .NUM_BITS(8), .GAP_PHASES(16), .DEBOUNCE_FRAMES(1)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .scan_en(scan_en_b),
    .hc165_clk(clk_b), .hc165_ld_n(ldn_b), .hc165_dat(dat_b),
    .frame_data(fd_b), .frame_valid(fv_b), .key_state(ks_b),
    .key_changed(kc_b), .busy(busy_b)
  );

  // Chain models: parallel load while SH/LD_n low, shift toward QH on CP rise.
  logic [31:0] par_a = 32'hA5C3_0F81;
  logic [31:0] chain_a = '0;
  logic        pclk_a = 1'b0;
  logic [7:0]  par_b = 8'h3C;
  logic [7:0]  chain_b = '0;
  logic        pclk_b = 1'b0;

  always @(posedge sys_clk) begin
    pclk_a <= clk_a;
    if (!ldn_a) chain_a <= par_a;
    else if (clk_a && !pclk_a) chain_a <= {chain_a[30:0], 1'b0};
    pclk_b <= clk_b;
    if (!ldn_b) chain_b <= par_b;
    else if (clk_b && !pclk_b) chain_b <= {chain_b[6:0], 1'b0};
  end
  assign dat_a = chain_a[31];
  assign dat_b = chain_b[7];

  int   cyc = 0, rises_a = 0, ldlen_a = 0, ldpulses_a = 0, kc_cnt_a = 0, orphan_kc = 0;
  logic pld_a = 1'b1;

  always @(posedge sys_clk) begin
    cyc   <= cyc + 1;
    pld_a <= ldn_a;
    if (!ldn_a && pld_a) begin
      ldlen_a    <= 1;
      rises_a    <= 0;
      ldpulses_a <= ldpulses_a + 1;
    end else begin
      if (!ldn_a) ldlen_a <= ldlen_a + 1;
      if (clk_a && !pclk_a) rises_a <= rises_a + 1;
    end
    if (kc_a) kc_cnt_a <= kc_cnt_a + 1;
    if ((kc_a && !fv_a) || (kc_b && !fv_b)) orphan_kc <= orphan_kc + 1;
  end

  int   tests = 0;
  int   fails = 0;
  int   fv_cyc = 0;
  logic kc_at = 1'b0;
  bit   got;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fv(input bit use_b, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge sys_clk); #1;
      if (use_b ? fv_b : fv_a) begin
        ok     = 1'b1;
        fv_cyc = cyc;
        kc_at  = use_b ? kc_b : kc_a;
        return;
      end
    end
  endtask

  // sel 0: ld_n low, 1: rises_a reaches val, 2: hc165_clk low (instance A)
  task automatic wait_a(input int sel, input int val, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge sys_clk); #1;
      if ((sel == 0 && !ldn_a) || (sel == 1 && rises_a == val) || (sel == 2 && !clk_a)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    int t1, kc0, lp;
    logic [31:0] v;

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_clk", clk_a, 0);
    check("rst_ldn", ldn_a, 1);
    check("rst_fd", fd_a, 0);
    check("rst_ks", ks_a, 0);
    check("rst_fv", fv_a, 0);
    check("rst_kc", kc_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_busy_b", busy_b, 0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check("idle_busy", busy_a, 0);
    scan_en_a = 1'b1;
    @(posedge sys_clk); #1;
    check("start_ldn", ldn_a, 0);
    check("start_busy", busy_a, 1);

    // Two frames of the same word: second one promotes it to key_state.
    wait_fv(1'b0, 3000, got);
    check("f1_seen", got, 1);
    check("f1_data", fd_a, 32'hA5C3_0F81);
    check("f1_key", ks_a, 0);
    check("f1_kc", kc_at, 0);
    check("f1_rises", rises_a, 31);
    check("f1_ldlen", ldlen_a, 25);
    check("f1_busy", busy_a, 1);
    t1 = fv_cyc;
    wait_fv(1'b0, 3000, got);
    check("f2_seen", got, 1);
    check("f2_data", fd_a, 32'hA5C3_0F81);
    check("f2_key", ks_a, 32'hA5C3_0F81);
    check("f2_kc", kc_at, 1);
    check("f2_spacing", fv_cyc - t1, 2001);
    check("f2_rises", rises_a, 31);

    // Reset pulse during the HIGH phase of bit 20.
    wait_a(0, 0, 3000, got);
    check("r_wait_ld", got, 1);
    wait_a(1, 21, 3000, got);
    check("r_wait_b20", got, 1);
    check("r_in_high", clk_a, 1);
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    check("mrst_clk", clk_a, 0);
    check("mrst_ldn", ldn_a, 1);
    check("mrst_fd", fd_a, 0);
    check("mrst_ks", ks_a, 0);
    check("mrst_busy", busy_a, 0);
    wait_fv(1'b0, 3000, got);
    check("rf_seen", got, 1);
    check("rf_data", fd_a, 32'hA5C3_0F81);
    check("rf_key", ks_a, 0);
    check("rf_kc", kc_at, 0);

    // Alternating glitch frames never pass the debouncer.
    kc0 = kc_cnt_a;
    for (int k = 0; k < 4; k++) begin
      v = (k % 2 == 0) ? 32'h1 : 32'h0;
      par_a = v;
      wait_fv(1'b0, 3000, got);
      check("alt_seen", got, 1);
      check("alt_data", fd_a, v);
      check("alt_key", ks_a, 0);
    end
    check("alt_nokc", kc_cnt_a - kc0, 0);
    par_a = 32'h1;
    for (int k = 0; k < 3; k++) begin
      wait_fv(1'b0, 3000, got);
      check("run_seen", got, 1);
      check("run_key", ks_a, (k == 0) ? 32'h0 : 32'h1);
      check("run_kc", kc_at, (k == 1) ? 1 : 0);
    end
    check("run_kc_count", kc_cnt_a - kc0, 1);

    // Drop scan_en during LOW of bit 10; frame must still complete.
    par_a = 32'h8000_0401;
    wait_a(0, 0, 3000, got);
    check("s_wait_ld", got, 1);
    wait_a(1, 10, 3000, got);
    check("s_wait_b9", got, 1);
    wait_a(2, 0, 100, got);
    check("s_wait_low", got, 1);
    scan_en_a = 1'b0;
    wait_fv(1'b0, 3000, got);
    check("s_seen", got, 1);
    check("s_data", fd_a, 32'h8000_0401);
    check("s_key", ks_a, 32'h1);
    check("s_kc", kc_at, 0);
    lp = ldpulses_a;
    repeat (600) @(posedge sys_clk);
    #1;
    check("s_idle_busy", busy_a, 0);
    check("s_idle_ldn", ldn_a, 1);
    check("s_idle_clk", clk_a, 0);
    check("s_no_ld", ldpulses_a - lp, 0);
    check("s_hold_data", fd_a, 32'h8000_0401);
    scan_en_a = 1'b1;
    @(posedge sys_clk); #1;
    check("s_restart_ldn", ldn_a, 0);
    check("s_restart_busy", busy_a, 1);
    scan_en_a = 1'b0;

    // Single-frame debounce on the short chain.
    scan_en_b = 1'b1;
    wait_fv(1'b1, 400, got);
    check("b1_seen", got, 1);
    check("b1_data", fd_b, 8'h3C);
    check("b1_key", ks_b, 8'h3C);
    check("b1_kc", kc_at, 1);
    t1 = fv_cyc;
    par_b = 8'hC3;
    wait_fv(1'b1, 400, got);
    check("b2_seen", got, 1);
    check("b2_data", fd_b, 8'hC3);
    check("b2_key", ks_b, 8'hC3);
    check("b2_kc", kc_at, 1);
    check("b2_spacing", fv_cyc - t1, 129);
    scan_en_b = 1'b0;

    check("orphan_kc", orphan_kc, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
